// File: rtl/y_change_apply.sv
// Read-modify-write engine ahead of the Y admittance SRAM write port.
// Each change record adds a saturated complex delta to one lane of a 256-bit word.
module y_change_apply #(
  parameter int N_ROWS        = 64,
  parameter int N_COLS        = 64,
  parameter int WORDS_PER_ROW = 13,
  parameter int RD_LAT        = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         chg_valid,
  output logic         chg_ready,
  input  logic         chg_last,
  input  logic [15:0]  chg_row,
  input  logic [15:0]  chg_col,
  input  logic [23:0]  chg_real,
  input  logic [23:0]  chg_img,
  output logic [10:0]  rd_addr,
  input  logic [255:0] rd_data,
  output logic         wr_en,
  output logic [10:0]  wr_addr,
  output logic [255:0] wr_data,
  output logic         err_range,
  output logic         done,
  output logic [15:0]  applied_cnt
);

  typedef enum logic [2:0] {IDLE, CHK, DIV, RD, WT, MOD, WR} state_t;

  state_t state_q, state_d;

  logic [15:0]  row_q, row_d;
  logic [15:0]  rem_q, rem_d;
  logic [15:0]  quo_q, quo_d;
  logic [23:0]  real_q, real_d;
  logic [23:0]  img_q, img_d;
  logic         last_q, last_d;
  logic [7:0]   wt_cnt_q, wt_cnt_d;
  logic [255:0] word_q, word_d;
  logic [10:0]  rd_addr_q, rd_addr_d;
  logic [10:0]  wr_addr_q, wr_addr_d;
  logic [255:0] wr_data_q, wr_data_d;
  logic [15:0]  applied_cnt_q, applied_cnt_d;

  logic         out_of_range;
  logic         wt_done;
  logic [255:0] mod_word;

  // Two's complement add clamped to the signed 24-bit range.
  function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] s;
    s = {a[23], a} + {b[23], b};
    if (s[24] != s[23]) return s[24] ? 24'h800000 : 24'h7FFFFF;
    return s[23:0];
  endfunction

  assign out_of_range = (32'(row_q) >= 32'(N_ROWS)) || (32'(rem_q) >= 32'(N_COLS));
  assign wt_done      = (32'(wt_cnt_q) >= 32'(RD_LAT - 1));

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (chg_valid) state_d = CHK;
      CHK:  state_d = out_of_range ? IDLE : DIV;
      DIV:  if (rem_q < 16'd5) state_d = RD;
      RD:   state_d = WT;
      WT:   if (wt_done) state_d = MOD;
      MOD:  state_d = WR;
      WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the lane selected by the column remainder is touched; reserved bits ride along.
  always_comb begin
    mod_word = word_q;
    for (int k = 0; k < 5; k++) begin
      if (rem_q == 16'(k)) begin
        mod_word[48*k +: 48] = {sat_add(word_q[48*k+24 +: 24], real_q),
                                sat_add(word_q[48*k +: 24], img_q)};
      end
    end
  end

  always_comb begin
    row_d         = row_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    real_d        = real_q;
    img_d         = img_q;
    last_d        = last_q;
    wt_cnt_d      = wt_cnt_q;
    word_d        = word_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    applied_cnt_d = applied_cnt_q;
    case (state_q)
      IDLE: begin
        if (chg_valid) begin
          row_d  = chg_row;
          rem_d  = chg_col;
          quo_d  = 16'd0;
          real_d = chg_real;
          img_d  = chg_img;
          last_d = chg_last;
        end
      end
      DIV: begin
        // Column-to-word mapping by repeated subtraction of the 5-lane word width.
        if (rem_q >= 16'd5) begin
          rem_d = rem_q - 16'd5;
          quo_d = quo_q + 16'd1;
        end else begin
          rd_addr_d = 11'(32'(row_q) * 32'(WORDS_PER_ROW) + 32'(quo_q));
        end
      end
      RD: wt_cnt_d = 8'd0;
      WT: begin
        wt_cnt_d = wt_cnt_q + 8'd1;
        if (wt_done) word_d = rd_data;
      end
      MOD: begin
        wr_addr_d = rd_addr_q;
        wr_data_d = mod_word;
      end
      WR: applied_cnt_d = applied_cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      row_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      real_q        <= '0;
      img_q         <= '0;
      last_q        <= 1'b0;
      wt_cnt_q      <= '0;
      word_q        <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      applied_cnt_q <= '0;
    end else begin
      row_q         <= row_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      real_q        <= real_d;
      img_q         <= img_d;
      last_q        <= last_d;
      wt_cnt_q      <= wt_cnt_d;
      word_q        <= word_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      applied_cnt_q <= applied_cnt_d;
    end
  end

  // Strobes are gated by reset so nothing is seen while reset is held low.
  always_comb begin
    chg_ready   = reset && (state_q == IDLE);
    wr_en       = reset && (state_q == WR);
    err_range   = reset && (state_q == CHK) && out_of_range;
    done        = reset && last_q &&
                  (((state_q == CHK) && out_of_range) || (state_q == WR));
    rd_addr     = rd_addr_q;
    wr_addr     = wr_addr_q;
    wr_data     = wr_data_q;
    applied_cnt = applied_cnt_q;
  end

endmodule

// File: tb/tb_y_change_apply.sv
// Directed bench for y_change_apply with a one-cycle-latency SRAM model.
// Expected words are built from hand-computed lane values.
module tb_y_change_apply;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         chg_valid = 1'b0;
  logic         chg_ready;
  logic         chg_last = 1'b0;
  logic [15:0]  chg_row = '0;
  logic [15:0]  chg_col = '0;
  logic [23:0]  chg_real = '0;
  logic [23:0]  chg_img = '0;
  logic [10:0]  rd_addr;
  logic [255:0] rd_data;
  logic         wr_en;
  logic [10:0]  wr_addr;
  logic [255:0] wr_data;
  logic         err_range;
  logic         done;
  logic [15:0]  applied_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] mem [0:2047];
  logic         pre_en = 1'b0;
  logic [10:0]  pre_addr = '0;
  logic [255:0] pre_data = '0;

  localparam logic [255:0] BASE =
    256'hDEAD_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2;

  y_change_apply dut (
    .clock(clock), .reset(reset),
    .chg_valid(chg_valid), .chg_ready(chg_ready), .chg_last(chg_last),
    .chg_row(chg_row), .chg_col(chg_col), .chg_real(chg_real), .chg_img(chg_img),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_range(err_range), .done(done), .applied_cnt(applied_cnt)
  );

  always #5 clock = ~clock;

  // SRAM model: registered read (RD_LAT=1), DUT write port, plus a bench preload port.
  always @(posedge clock) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [10:0] a, input logic [255:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  // Presents one record; returns at the falling edge of the first cycle after acceptance.
  task automatic applyStimulus(input logic [15:0] row, input logic [15:0] col,
                               input logic [23:0] re, input logic [23:0] im, input logic last);
    @(negedge clock);
    chg_row = row; chg_col = col; chg_real = re; chg_img = im; chg_last = last;
    chg_valid = 1'b1;
    for (int i = 0; i < 20 && chg_ready !== 1'b1; i++) @(negedge clock);
    checkOutput("accept_ready", 256'(chg_ready), 256'(1'b1));
    @(posedge clock);
    @(negedge clock);
    chg_valid = 1'b0; chg_last = 1'b0;
  endtask

  // Returns the post-accept cycle index of the wr_en pulse, or -1 if none within bound.
  task automatic waitWrite(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      if (wr_en === 1'b1) begin
        cyc = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int cyc;
    int seen;
    logic [255:0] w;
    logic [255:0] exp_w;

    // Reset held low while the SRAM model is preloaded.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_ready", 256'(chg_ready), 256'(1'b0));
    checkOutput("rst_wr_en", 256'(wr_en), 256'(1'b0));
    checkOutput("rst_rd_addr", 256'(rd_addr), 256'(11'd0));

    w = BASE; w[143:96] = {24'd1000, 24'd200};
    preload(11'd27, w);
    w = BASE; w[47:0] = {24'd8388600, 24'd7};
    preload(11'd0, w);
    preload(11'd13, 256'd0);
    preload(11'd39, BASE);

    reset = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_ready", 256'(chg_ready), 256'(1'b1));
    checkOutput("post_rst_wr_en", 256'(wr_en), 256'(1'b0));
    checkOutput("post_rst_cnt", 256'(applied_cnt), 256'(16'd0));
    checkOutput("post_rst_done", 256'({err_range, done}), 256'(2'b00));

    // row 2, col 7 -> word 27, lane 2; 1000+100, 200-50.
    applyStimulus(16'd2, 16'd7, 24'd100, 24'hFFFFCE, 1'b0);
    waitWrite(cyc);
    checkOutput("t2_latency", 256'(cyc), 256'(7));
    checkOutput("t2_rd_addr", 256'(rd_addr), 256'(11'd27));
    checkOutput("t2_wr_addr", 256'(wr_addr), 256'(11'd27));
    exp_w = BASE; exp_w[143:96] = {24'd1100, 24'd150};
    checkOutput("t2_wr_data", wr_data, exp_w);
    checkOutput("t2_done", 256'(done), 256'(1'b0));
    @(negedge clock);
    checkOutput("t2_wr_en_off", 256'(wr_en), 256'(1'b0));
    checkOutput("t2_cnt", 256'(applied_cnt), 256'(16'd1));

    // Positive saturation on lane 0 of word 0.
    applyStimulus(16'd0, 16'd0, 24'd10, 24'd0, 1'b0);
    waitWrite(cyc);
    checkOutput("t3a_latency", 256'(cyc), 256'(6));
    checkOutput("t3a_wr_addr", 256'(wr_addr), 256'(11'd0));
    exp_w = BASE; exp_w[47:0] = {24'h7FFFFF, 24'd7};
    checkOutput("t3a_wr_data", wr_data, exp_w);

    // Negative saturation: -8388600 - 20 clamps to -8388608; imag 7 - 3 = 4.
    w = BASE; w[47:0] = {24'h800008, 24'd7};
    preload(11'd0, w);
    applyStimulus(16'd0, 16'd0, 24'hFFFFEC, 24'hFFFFFD, 1'b0);
    waitWrite(cyc);
    exp_w = BASE; exp_w[47:0] = {24'h800000, 24'd4};
    checkOutput("t3b_wr_data", wr_data, exp_w);
    @(negedge clock);
    checkOutput("t3b_cnt", 256'(applied_cnt), 256'(16'd3));

    // Back-to-back records to word 13, lane 3; second one carries chg_last.
    applyStimulus(16'd1, 16'd3, 24'd5, 24'd0, 1'b0);
    waitWrite(cyc);
    exp_w = '0; exp_w[191:168] = 24'd5;
    checkOutput("t4a_wr_data", wr_data, exp_w);
    checkOutput("t4a_wr_addr", 256'(wr_addr), 256'(11'd13));
    applyStimulus(16'd1, 16'd3, 24'd5, 24'd0, 1'b1);
    waitWrite(cyc);
    checkOutput("t4b_latency", 256'(cyc), 256'(6));
    checkOutput("t4b_rd_data", 256'(rd_data[191:168]), 256'(24'd5));
    exp_w = '0; exp_w[191:168] = 24'd10;
    checkOutput("t4b_wr_data", wr_data, exp_w);
    checkOutput("t4b_done", 256'(done), 256'(1'b1));
    @(negedge clock);
    checkOutput("t4b_done_off", 256'(done), 256'(1'b0));
    checkOutput("t4b_cnt", 256'(applied_cnt), 256'(16'd5));

    // Out-of-range row with chg_last: err_range and done together, no write.
    applyStimulus(16'd64, 16'd0, 24'd1, 24'd1, 1'b1);
    checkOutput("t5_err", 256'(err_range), 256'(1'b1));
    checkOutput("t5_done", 256'(done), 256'(1'b1));
    checkOutput("t5_wr_en", 256'(wr_en), 256'(1'b0));
    @(negedge clock);
    checkOutput("t5_err_off", 256'({err_range, done}), 256'(2'b00));
    checkOutput("t5_ready", 256'(chg_ready), 256'(1'b1));
    seen = 0;
    repeat (8) begin
      if (wr_en === 1'b1) seen++;
      @(negedge clock);
    end
    checkOutput("t5_no_write", 256'(seen), 256'(0));
    checkOutput("t5_cnt", 256'(applied_cnt), 256'(16'd5));

    // Reset asserted during WT (cycle 4 after accept for col < 5).
    applyStimulus(16'd3, 16'd1, 24'd7, 24'd7, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("t6_rd_addr", 256'(rd_addr), 256'(11'd39));
    reset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (wr_en === 1'b1) seen++;
    end
    checkOutput("t6_rst_ready", 256'(chg_ready), 256'(1'b0));
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_ready", 256'(chg_ready), 256'(1'b1));
    checkOutput("t6_cnt", 256'(applied_cnt), 256'(16'd0));
    checkOutput("t6_rd_addr_rst", 256'(rd_addr), 256'(11'd0));
    repeat (10) begin
      if (wr_en === 1'b1) seen++;
      @(negedge clock);
    end
    checkOutput("t6_no_write", 256'(seen), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
